// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button event arbiter: edge-selection codes,
// FSM state encodings and a round-robin helper.
package button_event_arbiter_pkg;

  // EDGE_MODE parameter values
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // Arbiter FSM encodings (kept as plain constants for legacy compatibility)
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // Index following idx in a ring of n entries
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event handshake bundle between the arbiter (master) and its consumer (slave).
interface button_event_arbiter_if #(
  parameter int unsigned ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_pol;

  modport master (output evt_valid, output evt_id, output evt_pol, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_pol, output evt_ready);
endinterface

// File: rtl/button_event_arbiter_edge_cell.sv
// Per-channel edge detector holding one pending event plus a sticky overflow flag.
import button_event_arbiter_pkg::*;

module evt_edge_cell #(
  parameter int unsigned EDGE_MODE = EDGE_RISE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  input  logic en_i,
  input  logic accept_i,
  input  logic ovf_clr_i,
  output logic pending_o,
  output logic pol_o,
  output logic ovf_o
);

  logic prev_q, prev_d;
  logic pending_q, pending_d;
  logic pol_q, pol_d;
  logic ovf_q, ovf_d;
  logic rise, fall, edge_hit, qual;

  assign rise = level_i & ~prev_q;
  assign fall = ~level_i & prev_q;

  // Select which transitions count as events for this build
  always_comb begin
    case (EDGE_MODE)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      default:   edge_hit = rise | fall;
    endcase
  end

  assign qual = en_i & edge_hit;

  // Pending/overflow update; an accept in the same cycle frees the slot for a new edge
  always_comb begin
    prev_d    = level_i;
    pending_d = pending_q;
    pol_d     = pol_q;
    ovf_d     = ovf_q;
    if (accept_i) begin
      pending_d = 1'b0;
    end
    if (qual && (!pending_q || accept_i)) begin
      pending_d = 1'b1;
      pol_d     = rise;
    end
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (qual && pending_q && !accept_i) begin
      ovf_d = 1'b1;
    end
  end

  // Channel state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      pol_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      pol_q     <= pol_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending_o = pending_q;
  assign pol_o     = pol_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Collects per-channel button edges and serialises them round-robin onto a
// valid/ready event handshake.
import button_event_arbiter_pkg::*;

module button_event_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned EDGE_MODE = EDGE_RISE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           level,
  input  logic [N-1:0]           ch_en,
  output logic [N-1:0]           ovf,
  input  logic [N-1:0]           ovf_clr,
  button_event_arbiter_if.master evt_bus
);

  logic [N-1:0]    pending, pend_pol, acc_vec;
  logic            accept;
  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic            evt_pol_q, evt_pol_d;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  assign accept = (state_q == ST_OFFER) & evt_bus.evt_ready;

  // Route the accept strobe to the channel currently being offered
  always_comb begin
    acc_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      acc_vec[i] = accept && (evt_id_q == ID_W'(i));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cell
    evt_edge_cell #(.EDGE_MODE(EDGE_MODE)) u_cell (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .level_i   (level[g]),
      .en_i      (ch_en[g]),
      .accept_i  (acc_vec[g]),
      .ovf_clr_i (ovf_clr[g]),
      .pending_o (pending[g]),
      .pol_o     (pend_pol[g]),
      .ovf_o     (ovf[g])
    );
  end

  // First pending channel at or after rr_ptr, wrapping modulo N
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idx_t;
    idx        = 0;
    idx_t      = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_t = ID_W'(idx);
      if (!pick_found && pending[idx_t]) begin
        pick_found = 1'b1;
        pick_idx   = idx_t;
      end
    end
  end

  // IDLE latches the next winner; OFFER holds it until accepted
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    evt_id_d  = evt_id_q;
    evt_pol_d = evt_pol_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          evt_id_d  = pick_idx;
          evt_pol_d = pend_pol[pick_idx];
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (accept) begin
          rr_ptr_d = ID_W'(rr_next(int'(evt_id_q), N));
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      evt_id_q  <= '0;
      evt_pol_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      evt_id_q  <= evt_id_d;
      evt_pol_q <= evt_pol_d;
    end
  end

  assign evt_bus.evt_valid = (state_q == ST_OFFER);
  assign evt_bus.evt_id    = evt_id_q;
  assign evt_bus.evt_pol   = evt_pol_q;

endmodule
